// File: rtl/minirisc_pkg.sv
// Shared MiniRISC decode definitions: instruction field positions, opcode
// class codes, immediate-select encoding and the skid-buffer state type.
package minirisc_pkg;

   localparam int OPCODE_W  = 6;

   localparam int OP_MSB    = 31;
   localparam int OP_LSB    = 26;
   localparam int RS_MSB    = 25;
   localparam int RS_LSB    = 21;
   localparam int RT_MSB    = 20;
   localparam int RT_LSB    = 16;
   localparam int SHAMT_MSB = 15;
   localparam int SHAMT_LSB = 11;
   localparam int FUNC_MSB  = 4;
   localparam int FUNC_LSB  = 0;
   localparam int IMM16_MSB = 15;
   localparam int IMM22_MSB = 21;
   localparam int IMM26_MSB = 25;

   // Instruction class, taken from the top two opcode bits
   localparam logic [1:0] CLASS_R   = 2'b00;
   localparam logic [1:0] CLASS_I16 = 2'b01;
   localparam logic [1:0] CLASS_I22 = 2'b10;
   localparam logic [1:0] CLASS_J   = 2'b11;

   typedef enum logic [1:0] {
      IMM_NONE = 2'b00,
      IMM16    = 2'b01,
      IMM22    = 2'b10,
      IMM28    = 2'b11
   } imm_sel_t;

   // Encoded as {head valid, skid valid}
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'b00,
      BUF_ONE   = 2'b10,
      BUF_FULL  = 2'b11
   } buf_state_e;

   function automatic imm_sel_t immSelOf(input logic [1:0] opClass);
      imm_sel_t sel;
      case (opClass)
         CLASS_R:   sel = IMM_NONE;
         CLASS_I16: sel = IMM16;
         CLASS_I22: sel = IMM22;
         default:   sel = IMM28;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/skid_buf_2.sv
// Generic 2-entry valid/ready skid buffer: head register H feeds the output,
// skid register S absorbs one word of backpressure so inReady_o is registered.
module skid_buf_2
   import minirisc_pkg::*;
#(
   parameter int W = 64
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         flush_i,
   input  logic         inValid_i,
   output logic         inReady_o,
   input  logic [W-1:0] inData_i,
   output logic         outValid_o,
   input  logic         outReady_i,
   output logic [W-1:0] outData_o
);

   buf_state_e state_q, state_d;
   logic [W-1:0] head_q;
   logic [W-1:0] skid_q;
   logic         headValid;
   logic         skidValid;
   logic         accept;
   logic         pop;
   logic         headLoad;
   logic         headFromSkid;
   logic         skidLoad;

   assign headValid  = (state_q == BUF_ONE) || (state_q == BUF_FULL);
   assign skidValid  = (state_q == BUF_FULL);
   assign inReady_o  = !skidValid;
   assign outValid_o = headValid;
   assign outData_o  = head_q;
   assign accept     = inValid_i && !skidValid;
   assign pop        = headValid && outReady_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= BUF_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Flush wins over everything and leaves the payload registers untouched
   always_comb begin
      state_d      = state_q;
      headLoad     = 1'b0;
      headFromSkid = 1'b0;
      skidLoad     = 1'b0;
      if (flush_i) begin
         state_d = BUF_EMPTY;
      end else begin
         case (state_q)
            BUF_EMPTY: begin
               if (accept) begin
                  headLoad = 1'b1;
                  state_d  = BUF_ONE;
               end
            end
            BUF_ONE: begin
               if (accept && pop) begin
                  headLoad = 1'b1;
               end else if (accept) begin
                  skidLoad = 1'b1;
                  state_d  = BUF_FULL;
               end else if (pop) begin
                  state_d = BUF_EMPTY;
               end
            end
            BUF_FULL: begin
               if (pop) begin
                  headFromSkid = 1'b1;
                  state_d      = BUF_ONE;
               end
            end
            default: state_d = BUF_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q <= '0;
         skid_q <= '0;
      end else begin
         if (headLoad) begin
            head_q <= inData_i;
         end else if (headFromSkid) begin
            head_q <= skid_q;
         end
         if (skidLoad) begin
            skid_q <= inData_i;
         end
      end
   end

endmodule

// File: rtl/instr_field_decode.sv
// IF/ID field-extraction stage: buffers {pc, instr} in a 2-entry skid buffer
// and slices the head entry. Define DECODE_STATS_EN to add event counters.
module instr_field_decode
   import minirisc_pkg::*;
#(
   parameter int PC_W = 32,
   parameter int OP_W = OPCODE_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [OP_W-1:0] out_op,
   output logic [4:0]      out_rs,
   output logic [4:0]      out_rt,
   output logic [4:0]      out_shamt,
   output logic [4:0]      out_func,
   output logic [15:0]     out_imm16,
   output logic [21:0]     out_imm22,
   output logic [27:0]     out_imm28,
   output logic [1:0]      out_imm_sel
`ifdef DECODE_STATS_EN
   ,
   output logic [31:0]     stat_decoded,
   output logic [31:0]     stat_flushed,
   output logic [31:0]     stat_stall
`endif
);

   localparam int DATA_W = PC_W + 32;

   logic [DATA_W-1:0] headData;
   logic [31:0]       headInstr;

   skid_buf_2 #(
      .W (DATA_W)
   ) u_skid_buf (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .flush_i    (flush),
      .inValid_i  (in_valid),
      .inReady_o  (in_ready),
      .inData_i   ({in_pc, in_instr}),
      .outValid_o (out_valid),
      .outReady_i (out_ready),
      .outData_o  (headData)
   );

   assign headInstr   = headData[31:0];
   assign out_pc      = headData[DATA_W-1:32];
   assign out_op      = headInstr[OP_MSB:OP_LSB];
   assign out_rs      = headInstr[RS_MSB:RS_LSB];
   assign out_rt      = headInstr[RT_MSB:RT_LSB];
   assign out_shamt   = headInstr[SHAMT_MSB:SHAMT_LSB];
   assign out_func    = headInstr[FUNC_MSB:FUNC_LSB];
   assign out_imm16   = headInstr[IMM16_MSB:0];
   assign out_imm22   = headInstr[IMM22_MSB:0];
   assign out_imm28   = {headInstr[IMM26_MSB:0], 2'b00};
   assign out_imm_sel = immSelOf(headInstr[OP_MSB -: 2]);

`ifdef DECODE_STATS_EN
   logic [31:0] statDecoded_q;
   logic [31:0] statFlushed_q;
   logic [31:0] statStall_q;
   logic [1:0]  heldCount;

   // out_valid mirrors H.valid and !in_ready mirrors S.valid
   assign heldCount    = {1'b0, out_valid} + {1'b0, !in_ready};
   assign stat_decoded = statDecoded_q;
   assign stat_flushed = statFlushed_q;
   assign stat_stall   = statStall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         statDecoded_q <= '0;
         statFlushed_q <= '0;
         statStall_q   <= '0;
      end else begin
         if (!flush && out_valid && out_ready) begin
            statDecoded_q <= statDecoded_q + 32'd1;
         end
         if (flush) begin
            statFlushed_q <= statFlushed_q + {30'd0, heldCount};
         end
         if (out_valid && !out_ready) begin
            statStall_q <= statStall_q + 32'd1;
         end
      end
   end
`endif

endmodule
